// File: rtl/sa_ws_feeder.sv
// sa_ws_feeder: host-side driver for a weight-stationary systolic array.
// Buffers one weight tile, issues it as an unbroken mode=0 burst (last row first),
// then streams activation vectors with mode=1 held. Each issued vector carries a tag
// through a LAT-deep pipeline so returning partial sums become a valid-qualified stream.
//
// Ports:
//   clk, reset_n             clock (posedge), asynchronous active-low reset
//   start, num_acts          begin a tile of num_acts activation vectors (IDLE only)
//   busy, done               high outside IDLE; one-cycle pulse at tile end
//   w_valid/w_ready/w_data   weight-row handshake (ARRHEIGHT rows per tile)
//   a_valid/a_ready/a_data   activation-vector handshake
//   sa_mode, sa_w_in_vec,
//   sa_a_in_vec              to array inputs
//   sa_ps_out_vec            from array partial-sum outputs
//   res_valid/res_data/
//   res_last                 realigned result stream (no backpressure)
//   stall_cnt                only with SA_WS_FEEDER_STALL_CNT_EN defined: COMP cycles
//                            without an activation handshake, saturating
module sa_ws_feeder #(
    parameter int unsigned ARRWIDTH  = 8,
    parameter int unsigned ARRHEIGHT = 8,
    parameter int unsigned WORDWIDTH = 8,
    parameter int unsigned LAT       = 17,
    parameter int unsigned CNTW      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [CNTW-1:0]                   num_acts,
    output logic                              busy,
    output logic                              done,
`ifdef SA_WS_FEEDER_STALL_CNT_EN
    output logic [31:0]                       stall_cnt,
`endif
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [WORDWIDTH*ARRWIDTH-1:0]     w_data,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [WORDWIDTH*ARRHEIGHT-1:0]    a_data,
    output logic                              sa_mode,
    output logic [WORDWIDTH*ARRWIDTH-1:0]     sa_w_in_vec,
    output logic [WORDWIDTH*ARRHEIGHT-1:0]    sa_a_in_vec,
    input  logic [WORDWIDTH*4*ARRWIDTH-1:0]   sa_ps_out_vec,
    output logic                              res_valid,
    output logic [WORDWIDTH*4*ARRWIDTH-1:0]   res_data,
    output logic                              res_last
);
    localparam int unsigned WW   = WORDWIDTH * ARRWIDTH;
    localparam int unsigned AW   = WORDWIDTH * ARRHEIGHT;
    localparam int unsigned PW   = WORDWIDTH * 4 * ARRWIDTH;
    localparam int unsigned RowW = (ARRHEIGHT > 1) ? $clog2(ARRHEIGHT) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(ARRHEIGHT - 1);

    typedef enum logic [2:0] {StIdle, StWbuf, StWissue, StComp, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  num_q, num_d;
    logic [CNTW-1:0]  issued_q, issued_d;
    logic [CNTW-1:0]  received_q, received_d;
    logic [RowW-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]    wbuf_q [ARRHEIGHT];
    logic [WW-1:0]    wbuf_d [ARRHEIGHT];
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             w_ready_q, w_ready_d;
    logic             a_ready_q, a_ready_d;
    logic             sa_mode_q, sa_mode_d;
    logic [WW-1:0]    sa_w_q, sa_w_d;
    logic [AW-1:0]    sa_a_q, sa_a_d;
    logic             tag_q, tag_d;          // tag travelling alongside sa_a_q
    logic [LAT-1:0]   tag_sr_q, tag_sr_d;
    logic             res_valid_q, res_valid_d;
    logic [PW-1:0]    res_data_q, res_data_d;
    logic             res_last_q, res_last_d;
    logic [31:0]      stall_q, stall_d;
    logic             w_hs, a_hs, tag_exit;

    assign w_hs     = w_valid & w_ready_q;
    assign a_hs     = a_valid & a_ready_q;
    assign tag_exit = sa_mode_q & tag_sr_q[LAT-1];

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        issued_d    = issued_q;
        received_d  = received_q;
        cnt_d       = cnt_q;
        wbuf_d      = wbuf_q;
        done_d      = 1'b0;
        sa_w_d      = '0;
        sa_a_d      = '0;
        tag_d       = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_last_d  = 1'b0;
        stall_d     = stall_q;
        tag_sr_d    = tag_sr_q;

        // Tag pipeline only advances while the array is computing.
        if (sa_mode_q) begin
            tag_sr_d[0] = tag_q;
            for (int i = 1; i < LAT; i++) begin
                tag_sr_d[i] = tag_sr_q[i-1];
            end
        end

        if (tag_exit) begin
            res_valid_d = 1'b1;
            res_data_d  = sa_ps_out_vec;
            received_d  = received_q + 1'b1;
            res_last_d  = (received_d == num_q);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    issued_d   = '0;
                    received_d = '0;
                    stall_d    = '0;
                    if (num_acts != '0) begin
                        state_d = StWbuf;
                        num_d   = num_acts;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StWbuf: begin
                if (w_hs) begin
                    wbuf_d[cnt_q] = w_data;
                    if (cnt_q == LastRow) begin
                        // Last row goes straight out: it is the first one issued.
                        state_d = StWissue;
                        cnt_d   = '0;
                        sa_w_d  = w_data;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWissue: begin
                // cnt_q counts rows already on the output; next one is one row lower.
                if (cnt_q == LastRow) begin
                    state_d = StComp;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    sa_w_d = wbuf_q[LastRow - cnt_q - 1'b1];
                end
            end
            StComp: begin
                if (a_hs) begin
                    sa_a_d   = a_data;
                    tag_d    = 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_d == num_q) begin
                        state_d = StDrain;
                    end
                end else if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StDrain: begin
                if (received_q == num_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d    = (state_d != StIdle);
        w_ready_d = (state_d == StWbuf);
        a_ready_d = (state_d == StComp) && (issued_d < num_d);
        sa_mode_d = (state_d == StComp) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            num_q       <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < ARRHEIGHT; i++) begin
                wbuf_q[i] <= '0;
            end
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
            a_ready_q   <= 1'b0;
            sa_mode_q   <= 1'b0;
            sa_w_q      <= '0;
            sa_a_q      <= '0;
            tag_q       <= 1'b0;
            tag_sr_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            cnt_q       <= cnt_d;
            wbuf_q      <= wbuf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_ready_q   <= w_ready_d;
            a_ready_q   <= a_ready_d;
            sa_mode_q   <= sa_mode_d;
            sa_w_q      <= sa_w_d;
            sa_a_q      <= sa_a_d;
            tag_q       <= tag_d;
            tag_sr_q    <= tag_sr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            stall_q     <= stall_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign w_ready     = w_ready_q;
    assign a_ready     = a_ready_q;
    assign sa_mode     = sa_mode_q;
    assign sa_w_in_vec = sa_w_q;
    assign sa_a_in_vec = sa_a_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_last    = res_last_q;
`ifdef SA_WS_FEEDER_STALL_CNT_EN
    assign stall_cnt   = stall_q;
`else
    logic unused_stall;
    assign unused_stall = ^stall_q;
`endif

endmodule

// File: tb/tb_sa_ws_feeder.sv
module tb_sa_ws_feeder;
    localparam int unsigned LATV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_acts = '0;
    logic        busy, done;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [15:0] w_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [15:0] a_data = '0;
    logic        sa_mode;
    logic [15:0] sa_w_in_vec, sa_a_in_vec;
    logic [63:0] sa_ps_out_vec;
    logic        res_valid, res_last;
    logic [63:0] res_data;
`ifdef SA_WS_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sa_ws_feeder #(
        .ARRWIDTH (2),
        .ARRHEIGHT(2),
        .WORDWIDTH(8),
        .LAT      (LATV),
        .CNTW     (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .num_acts     (num_acts),
        .busy         (busy),
        .done         (done),
`ifdef SA_WS_FEEDER_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .sa_mode      (sa_mode),
        .sa_w_in_vec  (sa_w_in_vec),
        .sa_a_in_vec  (sa_a_in_vec),
        .sa_ps_out_vec(sa_ps_out_vec),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_last     (res_last)
    );

    // Array stand-in: the vector on sa_a_in_vec reappears LATV cycles later, wrapped
    // with a marker so bubbles also produce a non-zero partial-sum word.
    logic [15:0] hist [LATV];
    always @(posedge clk) begin
        hist[0] <= sa_a_in_vec;
        for (int k = 1; k < LATV; k++) hist[k] <= hist[k-1];
    end
    assign sa_ps_out_vec = {16'hF00D, 16'h0000, hist[LATV-1], hist[LATV-1]};

    function automatic logic [63:0] rexp(input logic [15:0] a);
        return {16'hF00D, 16'h0000, a, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a tile from IDLE, loads two weight rows and checks the reversed burst;
    // returns in the first COMP cycle. A second start (num=7) is raised while busy.
    task automatic begin_tile(input logic [15:0] n, input logic [15:0] r0,
                              input logic [15:0] r1);
        start = 1'b1; num_acts = n; tick();
        chk("wbuf_busy", 64'(busy), 64'd1);
        chk("wbuf_wready", 64'(w_ready), 64'd1);
        chk("wbuf_quiet", 64'(res_valid), 64'd0);
        start = 1'b1; num_acts = 16'd7;
        w_valid = 1'b1; w_data = r0; tick();
        chk("wbuf2_quiet", 64'(res_valid), 64'd0);
        start = 1'b0; w_data = r1; tick();
        chk("wissue0_mode", 64'(sa_mode), 64'd0);
        chk("wissue0_w", 64'(sa_w_in_vec), 64'(r1));
        chk("wissue0_wready", 64'(w_ready), 64'd0);
        chk("wissue0_quiet", 64'(res_valid), 64'd0);
        w_valid = 1'b0; w_data = '0; tick();
        chk("wissue1_mode", 64'(sa_mode), 64'd0);
        chk("wissue1_w", 64'(sa_w_in_vec), 64'(r0));
        chk("wissue1_aready", 64'(a_ready), 64'd0);
        chk("wissue1_quiet", 64'(res_valid), 64'd0);
        tick();
        chk("comp_mode", 64'(sa_mode), 64'd1);
        chk("comp_w", 64'(sa_w_in_vec), 64'd0);
        chk("comp_aready", 64'(a_ready), 64'd1);
        chk("comp_quiet", 64'(res_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wready", 64'(w_ready), 64'd0);
        chk("rst_aready", 64'(a_ready), 64'd0);
        chk("rst_mode", 64'(sa_mode), 64'd0);
        chk("rst_w", 64'(sa_w_in_vec), 64'd0);
        chk("rst_a", 64'(sa_a_in_vec), 64'd0);
        chk("rst_rvalid", 64'(res_valid), 64'd0);
        chk("rst_rdata", res_data, 64'd0);
        chk("rst_rlast", 64'(res_last), 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        tick();

        // Tile A: three back-to-back activations
        begin_tile(16'd3, 16'h0201, 16'h0403);
        a_valid = 1'b1; a_data = 16'h1111; tick();
        chk("A_a1", 64'(sa_a_in_vec), 64'h1111);
        chk("A_a1_mode", 64'(sa_mode), 64'd1);
        a_data = 16'h2222; tick();
        chk("A_a2", 64'(sa_a_in_vec), 64'h2222);
        a_data = 16'h3333; tick();
        chk("A_a3", 64'(sa_a_in_vec), 64'h3333);
        chk("A_aready_off", 64'(a_ready), 64'd0);
        a_valid = 1'b0; a_data = '0; tick();
        chk("A_drain_a", 64'(sa_a_in_vec), 64'd0);
        chk("A_drain_mode", 64'(sa_mode), 64'd1);
        chk("A_rv_c9", 64'(res_valid), 64'd0);
        tick();
        chk("A_rv_c10", 64'(res_valid), 64'd0);
        tick();
        chk("A_rv1", 64'(res_valid), 64'd1);
        chk("A_rd1", res_data, rexp(16'h1111));
        chk("A_rl1", 64'(res_last), 64'd0);
        tick();
        chk("A_rv2", 64'(res_valid), 64'd1);
        chk("A_rd2", res_data, rexp(16'h2222));
        chk("A_rl2", 64'(res_last), 64'd0);
        tick();
        chk("A_rv3", 64'(res_valid), 64'd1);
        chk("A_rd3", res_data, rexp(16'h3333));
        chk("A_rl3", 64'(res_last), 64'd1);
        chk("A_done_early", 64'(done), 64'd0);
        chk("A_busy_drain", 64'(busy), 64'd1);
        tick();
        chk("A_done", 64'(done), 64'd1);
        chk("A_mode_off", 64'(sa_mode), 64'd0);
        chk("A_busy_off", 64'(busy), 64'd0);
        chk("A_rv_off", 64'(res_valid), 64'd0);
        chk("A_rd_hold", res_data, rexp(16'h3333));
        chk("A_rl_off", 64'(res_last), 64'd0);
        tick();
        chk("A_done_pulse", 64'(done), 64'd0);

        // Tile B: two-cycle activation gap; start while busy must not relatch num_acts
        begin_tile(16'd3, 16'hAAAA, 16'h5555);
        a_valid = 1'b1; a_data = 16'h0101; tick();
        chk("B_a1", 64'(sa_a_in_vec), 64'h0101);
        a_valid = 1'b0; a_data = 16'hDEAD; tick();
        chk("B_bub1_a", 64'(sa_a_in_vec), 64'd0);
        chk("B_bub1_mode", 64'(sa_mode), 64'd1);
        tick();
        chk("B_bub2_a", 64'(sa_a_in_vec), 64'd0);
        chk("B_bub2_mode", 64'(sa_mode), 64'd1);
        chk("B_bub2_aready", 64'(a_ready), 64'd1);
        a_valid = 1'b1; a_data = 16'h0202; tick();
        chk("B_a2", 64'(sa_a_in_vec), 64'h0202);
        a_data = 16'h0303; tick();
        chk("B_a3", 64'(sa_a_in_vec), 64'h0303);
        chk("B_aready_off", 64'(a_ready), 64'd0);
        a_valid = 1'b0; a_data = '0; tick();
        chk("B_rv1", 64'(res_valid), 64'd1);
        chk("B_rd1", res_data, rexp(16'h0101));
        tick();
        chk("B_gap1_rv", 64'(res_valid), 64'd0);
        chk("B_gap1_hold", res_data, rexp(16'h0101));
        tick();
        chk("B_gap2_rv", 64'(res_valid), 64'd0);
        tick();
        chk("B_rv2", 64'(res_valid), 64'd1);
        chk("B_rd2", res_data, rexp(16'h0202));
        chk("B_rl2", 64'(res_last), 64'd0);
        tick();
        chk("B_rv3", 64'(res_valid), 64'd1);
        chk("B_rd3", res_data, rexp(16'h0303));
        chk("B_rl3", 64'(res_last), 64'd1);
        tick();
        chk("B_done", 64'(done), 64'd1);
        chk("B_busy_off", 64'(busy), 64'd0);
`ifdef SA_WS_FEEDER_STALL_CNT_EN
        chk("B_stall", 64'(stall_cnt), 64'd2);
`endif
        tick();
        chk("B_done_pulse", 64'(done), 64'd0);
`ifdef SA_WS_FEEDER_STALL_CNT_EN
        chk("B_stall_hold", 64'(stall_cnt), 64'd2);
`endif

        // Zero-length tile
        start = 1'b1; num_acts = 16'd0; tick();
        chk("Z_done", 64'(done), 64'd1);
        chk("Z_busy", 64'(busy), 64'd0);
        chk("Z_wready", 64'(w_ready), 64'd0);
`ifdef SA_WS_FEEDER_STALL_CNT_EN
        chk("Z_stall_clr", 64'(stall_cnt), 64'd0);
`endif
        start = 1'b0; tick();
        chk("Z_done_pulse", 64'(done), 64'd0);
        chk("Z_busy2", 64'(busy), 64'd0);

        // Reset during DRAIN with results in flight
        begin_tile(16'd2, 16'h0A0B, 16'h0C0D);
        a_valid = 1'b1; a_data = 16'h4444; tick();
        a_data = 16'h5555; tick();
        a_valid = 1'b0; a_data = '0; tick();
        chk("R_in_drain_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("R_busy", 64'(busy), 64'd0);
        chk("R_mode", 64'(sa_mode), 64'd0);
        chk("R_a", 64'(sa_a_in_vec), 64'd0);
        chk("R_aready", 64'(a_ready), 64'd0);
        chk("R_rv", 64'(res_valid), 64'd0);
        chk("R_rd", res_data, 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;

        // Fresh tile after reset: no stale results, single correct result
        begin_tile(16'd1, 16'h1357, 16'h2468);
        a_valid = 1'b1; a_data = 16'h0909; tick();
        chk("F_a1", 64'(sa_a_in_vec), 64'h0909);
        a_valid = 1'b0; a_data = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("F_quiet", 64'(res_valid), 64'd0);
        end
        tick();
        chk("F_rv", 64'(res_valid), 64'd1);
        chk("F_rd", res_data, rexp(16'h0909));
        chk("F_rl", 64'(res_last), 64'd1);
        tick();
        chk("F_done", 64'(done), 64'd1);
        chk("F_rv_off", 64'(res_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
